// File: rtl/key_press_detect.sv
// rtl/key_press_detect.sv - synchronises and debounces one active-low key into level, press/release/long pulses and a press count
// Long-press counter and long_pulse are built only when KEY_LONG_PRESS_EN is defined.
module key_press_detect #(
  parameter int T_DEBOUNCE = 1_000_000,
  parameter int T_LONG     = 50_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // The edge that leaves IDLE/HELD is the first stable sample, so the debounce
  // count only needs T_DEBOUNCE-1 further samples before the transition.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(T_DEBOUNCE - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_level_q, key_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  assign key_s = sync_q[1];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    press_cnt_d     = press_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_cnt_d   = press_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q          <= 2'b11;
      state_q         <= IDLE;
      cnt_q           <= '0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      sync_q          <= {sync_q[0], KEY_in};
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_LONG - 1);

  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             long_done_q, long_done_d;
  logic             long_pulse_q, long_pulse_d;

  // Held time is frozen while a release is being debounced, so a bounce
  // neither restarts nor advances the long-press measurement.
  always_comb begin
    long_cnt_d   = long_cnt_q;
    long_done_d  = long_done_q;
    long_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        long_cnt_d  = '0;
        long_done_d = 1'b0;
      end
      PRESS_DB: begin
        long_cnt_d = '0;
      end
      HELD: begin
        if (long_cnt_q == LONG_LAST) begin
          if (!long_done_q) begin
            long_pulse_d = 1'b1;
            long_done_d  = 1'b1;
          end
        end else begin
          long_cnt_d = long_cnt_q + CNT_ONE;
        end
      end
      default: begin
        long_cnt_d = long_cnt_q;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      long_cnt_q   <= '0;
      long_done_q  <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      long_done_q  <= long_done_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_pulse = long_pulse_q;
`else
  assign long_pulse = 1'b0;
`endif

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_press_detect.sv
// tb/tb_key_press_detect.sv - randomized and directed bench for key_press_detect against a run-length reference model
module tb_key_press_detect;

  localparam int T_DEBOUNCE = 4;
  localparam int T_LONG     = 16;
  localparam int CNT_W      = 8;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       KEY_in = 1'b1;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  key_press_detect #(
    .T_DEBOUNCE(T_DEBOUNCE),
    .T_LONG    (T_LONG),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .KEY_in       (KEY_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: debounced level changes after T_DEBOUNCE consecutive
  // synchronised samples that disagree with it
  bit m_s1, m_s2, m_pressed, m_long_done;
  int m_run, m_held, m_cnt;
  bit e_press, e_rel, e_long;

  int cyc, first_press_cyc, long_cyc, n_press_seen, n_rel_seen, n_long_seen, width_viol;
  bit prev_press, prev_rel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_long_done = 1'b0;
    m_run = 0; m_held = 0; m_cnt = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge(input bit key);
    bit ks;
    ks = m_s2;
    m_s2 = m_s1;
    m_s1 = key;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (!m_pressed) begin
      m_run = (ks == 1'b0) ? m_run + 1 : 0;
      if (m_run == T_DEBOUNCE) begin
        m_pressed = 1'b1; m_run = 0; m_held = 0; m_long_done = 1'b0;
        e_press = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end else begin
      if (m_run == 0) begin
        m_held++;
        if (LONG_EN && m_held == T_LONG && !m_long_done) begin
          e_long = 1'b1;
          m_long_done = 1'b1;
        end
      end
      m_run = (ks == 1'b1) ? m_run + 1 : 0;
      if (m_run == T_DEBOUNCE) begin
        m_pressed = 1'b0; m_run = 0;
        e_rel = 1'b1;
      end
    end
  endtask

  task automatic step(input bit key);
    KEY_in = key;
    @(posedge CLK);
    model_edge(key);
    #1;
    cyc++;
    check_eq("press_pulse", press_pulse, e_press);
    check_eq("release_pulse", release_pulse, e_rel);
    check_eq("long_pulse", long_pulse, e_long);
    check_eq("key_level", key_level, m_pressed);
    check_eq("press_cnt", press_cnt, m_cnt);
    if (press_pulse === 1'b1) begin
      n_press_seen++;
      if (first_press_cyc == 0) first_press_cyc = cyc;
      if (prev_press) width_viol++;
    end
    if (release_pulse === 1'b1) begin
      n_rel_seen++;
      if (prev_rel) width_viol++;
    end
    if (long_pulse === 1'b1) begin
      n_long_seen++;
      long_cyc = cyc;
    end
    prev_press = (press_pulse === 1'b1);
    prev_rel   = (release_pulse === 1'b1);
  endtask

  task automatic hold(input bit key, input int n);
    for (int i = 0; i < n; i++) step(key);
  endtask

  task automatic clear_obs();
    cyc = 0; first_press_cyc = 0; long_cyc = 0;
    n_press_seen = 0; n_rel_seen = 0; n_long_seen = 0;
  endtask

  // RST is raised mid-cycle so the zeroed outputs can only come from the async path
  task automatic do_reset_midcycle(input bit key);
    KEY_in = key;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_eq("rst_key_level", key_level, 0);
    check_eq("rst_press_pulse", press_pulse, 0);
    check_eq("rst_release_pulse", release_pulse, 0);
    check_eq("rst_long_pulse", long_pulse, 0);
    check_eq("rst_press_cnt", press_cnt, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    prev_press = 1'b0;
    prev_rel = 1'b0;
  endtask

  int cnt_before;
  int press_at;

  initial begin
    model_reset();
    clear_obs();
    width_viol = 0;
    prev_press = 1'b0;
    prev_rel = 1'b0;

    // reset with key held down, then first press latency
    do_reset_midcycle(1'b0);
    clear_obs();
    hold(1'b0, 10);
    check_eq("press_latency", first_press_cyc, 2 + T_DEBOUNCE);
    hold(1'b1, 12);

    // short glitch is rejected
    clear_obs();
    cnt_before = m_cnt;
    hold(1'b0, T_DEBOUNCE - 1);
    hold(1'b1, 10);
    check_eq("glitch_no_press", n_press_seen, 0);
    check_eq("glitch_cnt", press_cnt, cnt_before);

    // long hold
    clear_obs();
    hold(1'b0, 30);
    press_at = first_press_cyc;
    check_eq("long_hold_press", n_press_seen, 1);
    check_eq("long_count", n_long_seen, LONG_EN ? 1 : 0);
    check_eq("long_delay_cyc", long_cyc, LONG_EN ? press_at + T_LONG : 0);

    // release bounce shorter than debounce keeps key held
    clear_obs();
    hold(1'b1, 2);
    hold(1'b0, 5);
    check_eq("bounce_no_release", n_rel_seen, 0);
    check_eq("bounce_level", key_level, 1);
    hold(1'b1, 10);
    check_eq("release_once", n_rel_seen, 1);

    // 256 clean presses wrap the counter
    clear_obs();
    cnt_before = m_cnt;
    width_viol = 0;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, $urandom_range(T_DEBOUNCE, T_DEBOUNCE + 6));
      hold(1'b1, $urandom_range(T_DEBOUNCE, T_DEBOUNCE + 6));
    end
    check_eq("wrap_presses", n_press_seen, 256);
    check_eq("wrap_releases", n_rel_seen, 256);
    check_eq("wrap_cnt", press_cnt, cnt_before);
    check_eq("pulse_width", width_viol, 0);

    // reset while held: no release pulse, key re-detected afterwards
    hold(1'b0, 12);
    clear_obs();
    do_reset_midcycle(1'b0);
    hold(1'b0, 10);
    check_eq("rst_held_no_release", n_rel_seen, 0);
    check_eq("rst_held_redetect", n_press_seen, 1);
    check_eq("rst_held_cnt", press_cnt, 1);

    // random bouncy stimulus
    width_viol = 0;
    for (int blk = 0; blk < 600; blk++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, T_LONG + 6));
    end
    check_eq("random_pulse_width", width_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
